// File: rtl/fc_mux_pkg.sv
// fc_mux_pkg: shared types and helpers for the FC source selector.
package fc_mux_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GAP   = 2'd1,
    NOSRC = 2'd2
  } fc_state_e;

  localparam logic [7:0] FC_IDLE_WORD = 8'hAC;

  // Index of the lowest set bit; 0 when nothing is set (callers gate with |v).
  function automatic int lsb_index(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/fc_activity_mon.sv
// fc_activity_mon: counts transitions of one FC input over a shared window
// and reports whether it saw enough of them to be considered alive.
module fc_activity_mon #(
  parameter int MIN_TOGGLES = 16
) (
  input  logic clk,
  input  logic reset_in,
  input  logic fc_in,
  input  logic window_end,
  output logic active
);

  localparam int CW = $clog2(MIN_TOGGLES + 1);

  logic          fc_d;
  logic [CW-1:0] cnt;

  // Saturating toggle count; verdict latched and count cleared at window end.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      fc_d   <= 1'b0;
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      fc_d <= fc_in;
      if (window_end) begin
        active <= (cnt >= CW'(MIN_TOGGLES));
        cnt    <= '0;
      end else if ((fc_in != fc_d) && (cnt != CW'(MIN_TOGGLES))) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fc_source_selector.sv
// fc_source_selector: picks one of N_CH FC bit streams (manual or automatic
// failover) and only changes source on word boundaries, padding each change
// with GAP_WORDS idle words so downstream decoders never see a torn word.
module fc_source_selector
  import fc_mux_pkg::*;
#(
  parameter int                N_CH            = 4,
  parameter int                WORD_W          = 8,
  parameter logic [WORD_W-1:0] IDLE_WORD       = WORD_W'(FC_IDLE_WORD),
  parameter int                GAP_WORDS       = 2,
  parameter int                ACT_WINDOW      = 1024,
  parameter int                ACT_MIN_TOGGLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic [N_CH-1:0]         fc_in,
  input  logic [N_CH-1:0]         ch_enable,
  input  logic [N_CH-1:0]         ch_invert,
  input  logic                    auto_mode,
  input  logic [$clog2(N_CH)-1:0] manual_sel,
  input  logic                    bit_slip,
  output logic                    fc_out,
  output logic                    word_start,
  output logic [$clog2(N_CH)-1:0] cur_sel,
  output logic                    switching,
  output logic                    no_source,
  output logic [N_CH-1:0]         ch_active,
  output logic [15:0]             switch_count
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int BW    = $clog2(WORD_W);
  localparam int WW    = $clog2(ACT_WINDOW);
  localparam int GW    = $clog2(GAP_WORDS + 1);

  logic [BW-1:0]    bit_cnt, idle_idx;
  logic             slip_d, word_end, window_end;
  logic [WW-1:0]    win_cnt;
  logic [N_CH-1:0]  x, cand;
  fc_state_e        state, state_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [SEL_W-1:0] sel_nxt, tgt;
  logic             tgt_valid;
  logic [15:0]      cnt_nxt;

  assign x          = fc_in ^ ch_invert;
  assign cand       = ch_enable & ch_active;
  assign word_end   = (bit_cnt == BW'(WORD_W - 1)) && !bit_slip;
  assign window_end = (win_cnt == WW'(ACT_WINDOW - 1));
  assign idle_idx   = BW'(WORD_W - 1) - bit_cnt;

  // Word framing: a slip freezes the bit counter for the cycle it is seen.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      bit_cnt <= '0;
      slip_d  <= 1'b0;
    end else begin
      slip_d <= bit_slip;
      if (!bit_slip)
        bit_cnt <= (bit_cnt == BW'(WORD_W - 1)) ? '0 : bit_cnt + BW'(1);
    end
  end

  // Free-running activity window shared by all channel monitors.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) win_cnt <= '0;
    else          win_cnt <= window_end ? '0 : win_cnt + WW'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_act
    fc_activity_mon #(.MIN_TOGGLES(ACT_MIN_TOGGLES)) u_act (
      .clk        (clk),
      .reset_in   (reset_in),
      .fc_in      (fc_in[i]),
      .window_end (window_end),
      .active     (ch_active[i])
    );
  end

  // Target: sticky lowest-active-enabled channel in auto, else manual_sel.
  always_comb begin
    tgt       = cur_sel;
    tgt_valid = 1'b0;
    if (auto_mode) begin
      if (cand[cur_sel]) begin
        tgt_valid = 1'b1;
      end else if (|cand) begin
        tgt_valid = 1'b1;
        tgt       = SEL_W'(lsb_index(32'(cand)));
      end
    end else if ((int'(manual_sel) < N_CH) && ch_enable[manual_sel]) begin
      tgt_valid = 1'b1;
      tgt       = manual_sel;
    end
  end

  // Next-state logic; decisions are taken only at a non-slipped word end.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    sel_nxt   = cur_sel;
    cnt_nxt   = switch_count;
    if (word_end) begin
      case (state)
        RUN: begin
          if (!tgt_valid) begin
            state_nxt = NOSRC;
          end else if (tgt != cur_sel) begin
            state_nxt = GAP;
            gap_nxt   = GW'(GAP_WORDS - 1);
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_nxt = gap_cnt - GW'(1);
          end else if (tgt_valid) begin
            state_nxt = RUN;
            sel_nxt   = tgt;
            if (switch_count != 16'hFFFF) cnt_nxt = switch_count + 16'd1;
          end else begin
            state_nxt = NOSRC;
          end
        end
        NOSRC: begin
          if (tgt_valid) begin
            state_nxt = GAP;
            gap_nxt   = GW'(GAP_WORDS - 1);
          end
        end
        default: state_nxt = NOSRC;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state        <= NOSRC;
      gap_cnt      <= '0;
      cur_sel      <= '0;
      switch_count <= '0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_nxt;
      cur_sel      <= sel_nxt;
      switch_count <= cnt_nxt;
    end
  end

  // Output stage: one register so data and status share the same latency.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      fc_out     <= IDLE_WORD[WORD_W-1];
      word_start <= 1'b0;
      switching  <= 1'b0;
      no_source  <= 1'b1;
    end else begin
      fc_out     <= (state == RUN) ? x[cur_sel] : IDLE_WORD[idle_idx];
      word_start <= (bit_cnt == '0) && !slip_d;
      switching  <= (state == GAP);
      no_source  <= (state == NOSRC);
    end
  end

endmodule

// File: tb/tb_fc_source_selector.sv
// tb_fc_source_selector: scenario tasks with random stimulus, checked against
// a behavioural reference model of the selector kept in this bench.
`timescale 1ns/100ps
module tb_fc_source_selector;

  localparam int N_CH = 4, GAP_WORDS = 2, ACT_WINDOW = 1024, ACT_MIN = 16;
  localparam int S_RUN = 0, S_GAP = 1, S_NOSRC = 2;
  localparam logic [26:0] RST_VEC = {1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0, 16'd0};

  logic        clk = 1'b0;
  logic        reset_in;
  logic [3:0]  fc_in, ch_enable, ch_invert;
  logic        auto_mode, bit_slip;
  logic [1:0]  manual_sel;
  logic        fc_out, word_start, switching, no_source;
  logic [1:0]  cur_sel;
  logic [3:0]  ch_active;
  logic [15:0] switch_count;

  fc_source_selector dut (
    .clk(clk), .reset_in(reset_in), .fc_in(fc_in), .ch_enable(ch_enable),
    .ch_invert(ch_invert), .auto_mode(auto_mode), .manual_sel(manual_sel),
    .bit_slip(bit_slip), .fc_out(fc_out), .word_start(word_start),
    .cur_sel(cur_sel), .switching(switching), .no_source(no_source),
    .ch_active(ch_active), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic        m_fc, m_ws, m_sw, m_ns, m_held0;
  logic [1:0]  m_sel;
  logic [3:0]  m_active, m_prev;
  logic [15:0] m_cnt;
  int          m_state, m_gapleft, m_pos, m_cyc;
  int          m_tog[4];
  logic [7:0]  idle = 8'hAC;

  // Stimulus state: per-channel mode 0 hold, 1 toggle/2clk, 2 random, 3 sparse
  int mode[4];
  int gcyc = 0;
  bit slip_req = 0;

  logic [26:0] dut_vec, mdl_vec;
  assign dut_vec = {fc_out, word_start, cur_sel, switching, no_source, ch_active, switch_count};
  assign mdl_vec = {m_fc, m_ws, m_sel, m_sw, m_ns, m_active, m_cnt};

  task automatic model_reset();
    m_fc = idle[7]; m_ws = 0; m_sw = 0; m_ns = 1; m_held0 = 0;
    m_sel = 0; m_active = 0; m_prev = 0; m_cnt = 0;
    m_state = S_NOSRC; m_gapleft = 0; m_pos = 0; m_cyc = 0;
    for (int i = 0; i < 4; i++) m_tog[i] = 0;
  endtask

  // One clock of the selector, from its rules, using pre-edge values.
  task automatic model_step();
    logic [3:0] x;
    bit we, wend, tv;
    int tgt;
    if (reset_in) begin model_reset(); return; end
    x    = fc_in ^ ch_invert;
    we   = (m_pos == 7) && !bit_slip;
    wend = (m_cyc % ACT_WINDOW) == ACT_WINDOW - 1;
    tv = 0; tgt = 0;
    if (auto_mode) begin
      if (ch_enable[m_sel] && m_active[m_sel]) begin tv = 1; tgt = int'(m_sel); end
      else for (int i = N_CH - 1; i >= 0; i--)
        if (ch_enable[i] && m_active[i]) begin tv = 1; tgt = i; end
    end else if (ch_enable[manual_sel]) begin
      tv = 1; tgt = int'(manual_sel);
    end
    m_fc = (m_state == S_RUN) ? x[m_sel] : idle[7 - m_pos];
    m_ws = (m_pos == 0) && !m_held0;
    m_sw = (m_state == S_GAP);
    m_ns = (m_state == S_NOSRC);
    if (we) begin
      if (m_state == S_RUN) begin
        if (!tv) m_state = S_NOSRC;
        else if (tgt != int'(m_sel)) begin m_state = S_GAP; m_gapleft = GAP_WORDS; end
      end else if (m_state == S_GAP) begin
        m_gapleft--;
        if (m_gapleft == 0) begin
          if (tv) begin
            m_state = S_RUN; m_sel = 2'(tgt);
            if (m_cnt != 16'hFFFF) m_cnt++;
          end else m_state = S_NOSRC;
        end
      end else if (tv) begin
        m_state = S_GAP; m_gapleft = GAP_WORDS;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (wend) begin m_active[i] = (m_tog[i] >= ACT_MIN); m_tog[i] = 0; end
      else if (fc_in[i] != m_prev[i]) m_tog[i]++;
    end
    m_prev  = fc_in;
    m_held0 = bit_slip && (m_pos == 0);
    if (!bit_slip) m_pos = (m_pos + 1) % 8;
    m_cyc++;
  endtask

  // Drive the next input set at the falling edge, then advance one clock.
  task automatic tick();
    for (int i = 0; i < 4; i++)
      case (mode[i])
        1: if (gcyc % 2 == 0) fc_in[i] = ~fc_in[i];
        2: fc_in[i] = 1'($urandom_range(0, 1));
        3: if ($urandom_range(0, 63) == 0) fc_in[i] = ~fc_in[i];
        default: ;
      endcase
    bit_slip = slip_req;
    slip_req = 0;
    gcyc++;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_in = 1; fc_in = 0; ch_enable = 0; ch_invert = 0; auto_mode = 0;
    manual_sel = 0; bit_slip = 0;
    for (int i = 0; i < 4; i++) mode[i] = 0;
    model_reset();
    tick(); tick();
    n_cmp++;
    if (dut_vec !== RST_VEC) begin n_err++; $display("FAIL reset_values dut=%h exp=%h", dut_vec, RST_VEC); end
    n_cmp++;
    if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL reset_model dut=%h exp=%h", dut_vec, mdl_vec); end
    reset_in = 0;
  endtask

  task automatic test_bringup();
    logic [15:0] gap_bits;
    int nbits, nmiss;
    auto_mode = 1; ch_enable = 4'hF; mode[0] = 1;
    for (int i = 0; i < ACT_WINDOW - 1; i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL bringup_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
    end
    n_cmp++;
    if (ch_active !== 4'b0000) begin n_err++; $display("FAIL bringup_pre_window act=%b exp=0000", ch_active); end
    tick(); n_cmp++;
    if (ch_active !== 4'b0001) begin n_err++; $display("FAIL bringup_window act=%b exp=0001", ch_active); end
    gap_bits = 0; nbits = 0;
    for (int i = 0; i < 64 && switch_count != 16'd1; i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL bringup_gap_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
      if (switching) begin gap_bits = {gap_bits[14:0], fc_out}; nbits++; end
    end
    n_cmp++;
    if (switch_count !== 16'd1 || cur_sel !== 2'd0) begin
      n_err++; $display("FAIL bringup_switch cnt=%0d sel=%0d exp cnt=1 sel=0", switch_count, cur_sel);
    end
    n_cmp++;
    if (gap_bits !== 16'hACAC || nbits != 16) begin
      n_err++; $display("FAIL bringup_idle bits=%h n=%0d exp=acac n=16", gap_bits, nbits);
    end
    nmiss = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (fc_out !== fc_in[0]) nmiss++;
    end
    n_cmp++;
    if (nmiss != 0) begin n_err++; $display("FAIL bringup_delay misses=%0d exp=0", nmiss); end
  endtask

  task automatic test_failover();
    int sw_cyc;
    mode[0] = 0; mode[1] = 2;
    for (int i = 0; i < 2400 && ch_active !== 4'b0010; i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL failover_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
    end
    n_cmp++;
    if (ch_active !== 4'b0010) begin n_err++; $display("FAIL failover_active act=%b exp=0010", ch_active); end
    sw_cyc = 0;
    for (int i = 0; i < 200 && !(switch_count == 16'd2 && !switching); i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL failover_gap_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
      if (switching) sw_cyc++;
    end
    n_cmp++;
    if (sw_cyc != 16 || cur_sel !== 2'd1 || switch_count !== 16'd2) begin
      n_err++; $display("FAIL failover_switch sw=%0d sel=%0d cnt=%0d exp sw=16 sel=1 cnt=2", sw_cyc, cur_sel, switch_count);
    end
  endtask

  task automatic test_manual_invert();
    int zeros;
    auto_mode = 0; manual_sel = 2; ch_invert = 4'b0100; fc_in[2] = 0; mode[2] = 0;
    for (int i = 0; i < 64 && !(cur_sel == 2'd2 && !switching && !no_source); i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL manual_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
    end
    zeros = 0;
    for (int i = 0; i < 1100; i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL manual_run_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
      if (fc_out !== 1'b1) zeros++;
    end
    n_cmp++;
    if (zeros != 0 || cur_sel !== 2'd2 || ch_active[2] !== 1'b0 || no_source !== 1'b0) begin
      n_err++; $display("FAIL manual_invert zeros=%0d sel=%0d act2=%b nosrc=%b exp 0/2/0/0", zeros, cur_sel, ch_active[2], no_source);
    end
  endtask

  task automatic test_bit_slip();
    int last, n8, n9, nother, at;
    mode[2] = 2;
    for (int i = 0; i < 16 && !word_start; i++) tick();
    last = 0; n8 = 0; n9 = 0; nother = 0;
    at = 40 + $urandom_range(0, 7);
    for (int i = 1; i <= 120; i++) begin
      if (i == at) slip_req = 1;
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL slip_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
      if (word_start) begin
        if (i - last == 8) n8++; else if (i - last == 9) n9++; else nother++;
        last = i;
      end
    end
    n_cmp++;
    if (n9 != 1 || nother != 0 || n8 < 10) begin
      n_err++; $display("FAIL slip_intervals n8=%0d n9=%0d other=%0d exp n9=1 other=0", n8, n9, nother);
    end
  endtask

  task automatic test_invalid();
    logic [15:0] bits;
    ch_enable = 4'b0111; manual_sel = 3;
    for (int i = 0; i < 40 && !no_source; i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL invalid_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
    end
    n_cmp++;
    if (no_source !== 1'b1) begin n_err++; $display("FAIL invalid_nosrc nosrc=%b exp=1", no_source); end
    for (int i = 0; i < 16 && !word_start; i++) tick();
    bits = {15'd0, fc_out};
    for (int i = 0; i < 15; i++) begin tick(); bits = {bits[14:0], fc_out}; end
    n_cmp++;
    if (bits !== 16'hACAC) begin n_err++; $display("FAIL invalid_idle bits=%h exp=acac", bits); end
  endtask

  task automatic test_random();
    logic p_sw, p_ns;
    for (int i = 0; i < 6000; i++) begin
      if (i % 256 == 0) begin
        ch_enable = 4'($urandom_range(0, 15)); ch_invert = 4'($urandom_range(0, 15));
        auto_mode = ($urandom_range(0, 2) != 0); manual_sel = 2'($urandom_range(0, 3));
        for (int c = 0; c < 4; c++) mode[c] = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 49) == 0) slip_req = 1;
      p_sw = switching; p_ns = no_source;
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL random_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
      if (p_sw != switching || p_ns != no_source) begin
        n_cmp++;
        if (word_start !== 1'b1) begin n_err++; $display("FAIL random_midword ws=%b exp=1 t=%0t", word_start, $time); end
      end
    end
  endtask

  task automatic test_async_reset();
    auto_mode = 0; manual_sel = 0; ch_enable = 4'hF; ch_invert = 0;
    mode[0] = 2; mode[1] = 2; mode[2] = 0; mode[3] = 0;
    for (int i = 0; i < 2400 && !(cur_sel == 2'd0 && !switching && !no_source && ch_active != 0); i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL areset_pre_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
    end
    manual_sel = 1;
    for (int i = 0; i < 40 && !switching; i++) tick();
    n_cmp++;
    if (switching !== 1'b1) begin n_err++; $display("FAIL areset_gap sw=%b exp=1", switching); end
    #2 reset_in = 1; model_reset();
    #1;
    n_cmp++;
    if (switching !== 1'b0 || no_source !== 1'b1 || switch_count !== 16'd0 || ch_active !== 4'd0) begin
      n_err++; $display("FAIL areset_immediate sw=%b ns=%b cnt=%0d act=%b exp 0/1/0/0000", switching, no_source, switch_count, ch_active);
    end
    @(negedge clk);
    tick(); tick();
    reset_in = 0;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (switching !== 1'b0 || no_source !== 1'b1) begin
      n_err++; $display("FAIL areset_first_word sw=%b ns=%b exp 0/1", switching, no_source);
    end
    tick(); n_cmp++;
    if (switching !== 1'b1) begin n_err++; $display("FAIL areset_first_decision sw=%b exp=1", switching); end
    for (int i = 0; i < 40; i++) begin
      tick(); n_cmp++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL areset_post_model dut=%h exp=%h t=%0t", dut_vec, mdl_vec, $time); end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_failover();
    test_manual_invert();
    test_bit_slip();
    test_invalid();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time=%0t limit=3000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
